// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan display: hex decode table and
// the all-dark anode/segment patterns (everything active low).
package seg7_pkg;

  // Index 0 sits in the low bits; each entry is seg[6:0] = g..a, active low.
  localparam logic [15:0][6:0] SEG_HEX = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [3:0] AN_OFF  = 4'hF;

  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    return SEG_HEX[nib];
  endfunction

endpackage

// File: rtl/seg7_scan_display_hex_to_seg.sv
// Combinational nibble-to-segment decoder with decimal point; output active low.
module hex_to_seg
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  input  logic       dp,
  output logic [7:0] seg
);

  assign seg = {~dp, hex_decode(nib)};

endmodule

// File: rtl/seg7_scan_display.sv
// Time-multiplexed 4-digit common-anode 7-segment driver. Inputs are
// snapshotted once per scan frame so a changing value never shows a mixed image.
module seg7_scan_display
  import seg7_pkg::*;
#(
  parameter int SCAN_W = 17
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [15:0] hexs,
  input  logic [3:0]  points,
  input  logic [3:0]  le,
  input  logic        lzb,
  output logic [3:0]  an,
  output logic [7:0]  seg
);

  logic [SCAN_W-1:0] div;
  logic [1:0]        idx;
  logic [15:0]       sh_hexs;
  logic [3:0]        sh_points;
  logic [3:0]        sh_le;
  logic              sh_lzb;

  logic        tick;
  logic        boundary;
  logic [1:0]  nxt_idx;
  logic [15:0] cur_hexs;
  logic [3:0]  cur_points;
  logic [3:0]  cur_le;
  logic        cur_lzb;
  logic [3:0]  nib_p0;
  logic        z3;
  logic        z2;
  logic        z1;
  logic        lz_dark_p0;
  logic        dark_p0;
  logic [7:0]  dig_seg_p0;

  assign tick     = &div;
  assign nxt_idx  = idx + 2'd1;
  assign boundary = tick && (idx == 2'd3);

  // At the frame boundary the live inputs drive the first digit directly,
  // so the snapshot and what is shown for digit 0 always agree.
  assign cur_hexs   = boundary ? hexs   : sh_hexs;
  assign cur_points = boundary ? points : sh_points;
  assign cur_le     = boundary ? le     : sh_le;
  assign cur_lzb    = boundary ? lzb    : sh_lzb;

  assign nib_p0 = cur_hexs[{nxt_idx, 2'b00} +: 4];

  // Leading zeros: a digit blanks only if it and every digit above it are zero.
  assign z3 = (cur_hexs[15:12] == 4'h0);
  assign z2 = z3 && (cur_hexs[11:8] == 4'h0);
  assign z1 = z2 && (cur_hexs[7:4] == 4'h0);

  always_comb begin
    lz_dark_p0 = 1'b0;
    case (nxt_idx)
      2'd3:    lz_dark_p0 = cur_lzb && z3;
      2'd2:    lz_dark_p0 = cur_lzb && z2;
      2'd1:    lz_dark_p0 = cur_lzb && z1;
      default: lz_dark_p0 = 1'b0;
    endcase
  end

  assign dark_p0 = cur_le[nxt_idx] || lz_dark_p0;

  hex_to_seg u_hex_to_seg (
    .nib (nib_p0),
    .dp  (cur_points[nxt_idx]),
    .seg (dig_seg_p0)
  );

  // Registered outputs: update only on tick, hold in between.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      div       <= '0;
      idx       <= 2'd3;
      sh_hexs   <= '0;
      sh_points <= '0;
      sh_le     <= '0;
      sh_lzb    <= 1'b0;
      an        <= AN_OFF;
      seg       <= SEG_OFF;
    end else begin
      div <= div + {{(SCAN_W-1){1'b0}}, 1'b1};
      if (tick) begin
        idx <= nxt_idx;
        an  <= dark_p0 ? AN_OFF  : ~(4'b0001 << nxt_idx);
        seg <= dark_p0 ? SEG_OFF : dig_seg_p0;
      end
      if (boundary) begin
        sh_hexs   <= hexs;
        sh_points <= points;
        sh_le     <= le;
        sh_lzb    <= lzb;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Bench for seg7_scan_display with SCAN_W = 2 (one digit slot every 4 clk).
module tb_seg7_scan_display;

  logic        clk = 1'b0;
  logic        rstn;
  logic [15:0] hexs;
  logic [3:0]  points;
  logic [3:0]  le;
  logic        lzb;
  logic [3:0]  an;
  logic [7:0]  seg;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] an;
    logic [7:0] seg;
  } exp_t;

  typedef struct {
    logic [15:0] hexs;
    logic [3:0]  points;
    logic [3:0]  le;
    logic        lzb;
    logic [15:0] exp_an;   // slot 0 in [3:0]
    logic [31:0] exp_seg;  // slot 0 in [7:0]
  } vec_t;

  exp_t sb[$];
  vec_t vecs[9];

  seg7_scan_display #(.SCAN_W(2)) dut (
    .clk    (clk),
    .rstn   (rstn),
    .hexs   (hexs),
    .points (points),
    .le     (le),
    .lzb    (lzb),
    .an     (an),
    .seg    (seg)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [3:0] ea, input logic [7:0] es);
    checks++;
    if (an !== ea || seg !== es) begin
      errors++;
      $display("FAIL %s: got an=%h seg=%h, expected an=%h seg=%h", name, an, seg, ea, es);
    end
  endtask

  task automatic push(input logic [3:0] ea, input logic [7:0] es);
    exp_t e;
    e.an  = ea;
    e.seg = es;
    sb.push_back(e);
  endtask

  task automatic push_frame(input logic [15:0] ea, input logic [31:0] es);
    for (int s = 0; s < 4; s++) push(ea[s*4 +: 4], es[s*8 +: 8]);
  endtask

  // Wait one digit slot, then compare against the oldest scoreboard entry.
  task automatic consume(input string name);
    exp_t e;
    repeat (4) @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = sb.pop_front();
      check(name, e.an, e.seg);
    end
  endtask

  task automatic drive(input logic [15:0] h, input logic [3:0] p, input logic [3:0] l, input logic z);
    hexs   = h;
    points = p;
    le     = l;
    lzb    = z;
  endtask

  initial begin
    vecs[0] = '{16'h1234, 4'b0000, 4'b0000, 1'b0, 16'h7BDE, 32'hF9A4B099};
    vecs[1] = '{16'h0050, 4'b0000, 4'b0000, 1'b1, 16'hFFDE, 32'hFFFF92C0};
    vecs[2] = '{16'h0000, 4'b0000, 4'b0000, 1'b1, 16'hFFFE, 32'hFFFFFFC0};
    vecs[3] = '{16'h8888, 4'b0100, 4'b0000, 1'b0, 16'h7BDE, 32'h80008080};
    vecs[4] = '{16'h8888, 4'b0100, 4'b0010, 1'b0, 16'h7BFE, 32'h8000FF80};
    vecs[5] = '{16'h0005, 4'b1111, 4'b1000, 1'b1, 16'hFFFE, 32'hFFFFFF12};
    vecs[6] = '{16'h1234, 4'b1111, 4'b1111, 1'b0, 16'hFFFF, 32'hFFFFFFFF};
    vecs[7] = '{16'h0F00, 4'b0000, 4'b0000, 1'b1, 16'hFBDE, 32'hFF8EC0C0};
    vecs[8] = '{16'h6789, 4'b0000, 4'b0000, 1'b0, 16'h7BDE, 32'h82F88090};

    rstn = 1'b0;
    drive(16'h1234, 4'b0000, 4'b0000, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", 4'hF, 8'hFF);
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("post_reset_edge%0d", i), 4'hF, 8'hFF);
    end
    @(posedge clk);
    #1;
    check("first_digit", 4'hE, 8'h99);
    push(4'hD, 8'hB0);
    push(4'hB, 8'hA4);
    push(4'h7, 8'hF9);
    for (int s = 1; s < 4; s++) consume($sformatf("frame1_slot%0d", s));

    // idx is now 3: inputs applied here are captured at the next boundary.
    for (int v = 0; v < 9; v++) begin
      drive(vecs[v].hexs, vecs[v].points, vecs[v].le, vecs[v].lzb);
      push_frame(vecs[v].exp_an, vecs[v].exp_seg);
      for (int s = 0; s < 4; s++) consume($sformatf("vec%0d_slot%0d", v, s));
    end

    // Mid-frame change must not show until the following frame.
    drive(16'h1234, 4'b0000, 4'b0000, 1'b0);
    push(4'hE, 8'h99);
    push(4'hD, 8'hB0);
    consume("mid_slot0");
    consume("mid_slot1");
    hexs = 16'hABCD;
    push(4'hB, 8'hA4);
    push(4'h7, 8'hF9);
    consume("mid_old_slot2");
    consume("mid_old_slot3");
    push_frame(16'h7BDE, 32'h8883C6A1);
    for (int s = 0; s < 4; s++) consume($sformatf("mid_new_slot%0d", s));

    // Asynchronous reset between edges while idx = 2.
    push(4'hE, 8'hA1);
    push(4'hD, 8'hC6);
    push(4'hB, 8'h83);
    for (int s = 0; s < 3; s++) consume($sformatf("pre_areset_slot%0d", s));
    #2;
    rstn = 1'b0;
    #1;
    check("async_reset_no_edge", 4'hF, 8'hFF);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("areset_release_edge%0d", i), 4'hF, 8'hFF);
    end
    @(posedge clk);
    #1;
    check("areset_first_digit", 4'hE, 8'hA1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
